// File: rtl/mandel_iter_engine.sv
// Mandelbrot escape-depth engine: iterates z <- z^2 + c from z = 0, one step per clock.
// Optional period-2 bulb shortcut enabled by defining MANDEL_BULB_CHECK_EN.
module mandel_iter_engine #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 28,
  parameter int ITER_W = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] c_re,
  input  logic signed [DATA_W-1:0] c_im,
  input  logic        [ITER_W-1:0] max_iterations,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [ITER_W-1:0] depth,
  output logic        [ITER_W-1:0] max_iter_out
);

  localparam int MW = 2*DATA_W - FRAC_W + 1;
  localparam logic signed [MW-1:0] FOUR = MW'(4) <<< FRAC_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_DONE  = 2'd2
`ifdef MANDEL_BULB_CHECK_EN
    , S_CHECK = 2'd3
`endif
  } state_e;

  state_e                    state_q;
  logic signed [DATA_W-1:0]  z_re_q, z_im_q, c_re_q, c_im_q;
  logic signed [DATA_W-1:0]  z_re_d, z_im_d;
  logic        [ITER_W-1:0]  count_q, max_iter_q, depth_q, max_out_q;
  logic                      in_ready_q, out_valid_q;

  logic signed [2*DATA_W-1:0] p_rr, p_ii, p_ri;
  logic signed [MW-1:0]       zr2, zi2, mag;
  logic                       escape;

  // Squares keep every integer bit so a large |z| can never alias below 4.
  always_comb begin
    p_rr   = z_re_q * z_re_q;
    p_ii   = z_im_q * z_im_q;
    p_ri   = z_re_q * z_im_q;
    zr2    = MW'(p_rr >>> FRAC_W);
    zi2    = MW'(p_ii >>> FRAC_W);
    mag    = zr2 + zi2;
    escape = mag > FOUR;
    z_re_d = DATA_W'(zr2 - zi2) + c_re_q;
    // Shifting by FRAC_W-1 folds the factor 2 in without losing the LSB.
    z_im_d = DATA_W'(p_ri >>> (FRAC_W-1)) + c_im_q;
  end

`ifdef MANDEL_BULB_CHECK_EN
  localparam int BW = 2*DATA_W + 3;
  localparam logic signed [DATA_W:0] ONE      = (DATA_W+1)'(1) <<< FRAC_W;
  localparam logic signed [BW-1:0]   SIXTEENTH = BW'(1) <<< (FRAC_W-4);

  logic signed [DATA_W:0]     cr1;
  logic signed [2*DATA_W+1:0] p_b;
  logic signed [2*DATA_W-1:0] p_c;
  logic signed [BW-1:0]       bsum;
  logic                       in_bulb;

  always_comb begin
    cr1     = {c_re_q[DATA_W-1], c_re_q} + ONE;
    p_b     = cr1 * cr1;
    p_c     = c_im_q * c_im_q;
    bsum    = BW'(p_b >>> FRAC_W) + BW'(p_c >>> FRAC_W);
    in_bulb = bsum < SIXTEENTH;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      depth_q     <= '0;
      max_out_q   <= '0;
      z_re_q      <= '0;
      z_im_q      <= '0;
      c_re_q      <= '0;
      c_im_q      <= '0;
      count_q     <= '0;
      max_iter_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          c_re_q     <= c_re;
          c_im_q     <= c_im;
          max_iter_q <= max_iterations;
          z_re_q     <= '0;
          z_im_q     <= '0;
          count_q    <= '0;
          in_ready_q <= 1'b0;
`ifdef MANDEL_BULB_CHECK_EN
          state_q    <= S_CHECK;
`else
          state_q    <= S_ITER;
`endif
        end
`ifdef MANDEL_BULB_CHECK_EN
        S_CHECK: begin
          if (in_bulb) begin
            depth_q     <= max_iter_q;
            max_out_q   <= max_iter_q;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q     <= S_ITER;
          end
        end
`endif
        S_ITER: begin
          if (count_q == max_iter_q) begin
            depth_q     <= max_iter_q;
            max_out_q   <= max_iter_q;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (escape) begin
            depth_q     <= count_q;
            max_out_q   <= max_iter_q;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            z_re_q  <= z_re_d;
            z_im_q  <= z_im_d;
            count_q <= count_q + ITER_W'(1);
          end
        end
        S_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign depth        = depth_q;
  assign max_iter_out = max_out_q;

endmodule

// File: doc/mandel_iter_engine.md
Name: mandel_iter_engine

Overview:
- Producer of the per-pixel iteration depth that the LUT colouring stage consumes.
- Accepts one complex point c in signed fixed point and iterates z <- z^2 + c from z = 0, one iteration per clock.
- Reports the escape depth together with the max_iterations value it ran against. Depth equal to max_iterations means the point never escaped and is rendered black downstream.
- Sits between the pixel-coordinate generator and the colouring stage, with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 32: width of c_re, c_im, z_re, z_im (signed, two's complement).
- FRAC_W, 28: fractional bits (Q4.28 by default, range [-8, 8)).
- ITER_W, 10: width of depth and max_iterations.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  c_re/c_im/max_iterations are valid.
- in_ready  output  1  engine can accept a new point.
- c_re  input  DATA_W  real part of c, signed.
- c_im  input  DATA_W  imaginary part of c, signed.
- max_iterations  input  ITER_W  iteration limit for this point.
- out_valid  output  1  depth result is valid.
- out_ready  input  1  consumer accepts the result.
- depth  output  ITER_W  escape depth, or max_iterations if no escape.
- max_iter_out  output  ITER_W  max_iterations captured with this point.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; depth=0; max_iter_out=0.
  - Internal z, count and captured c cleared.
  - Reset mid-iteration abandons the point; no output is produced for it.
- States: IDLE, CHECK (only with the optional feature), ITER, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture c_re, c_im, max_iterations; z=0; count=0; go to ITER (or CHECK with the feature).
- ITER, one cycle per iteration. Evaluate in this priority order:
  1. If count==max_iter: depth<=max_iter, go to DONE.
  2. Else if |z|^2 > 4: depth<=count, go to DONE.
  3. Else: z_re<=zr2-zi2+c_re, z_im<=2*zr*zi+c_im, count<=count+1.
- Arithmetic rules:
  - Products are full 2*DATA_W signed, arithmetically shifted right by FRAC_W.
  - zr2, zi2 and the magnitude are kept at 2*DATA_W-FRAC_W+1 bits, with no truncation, so an escape is never missed.
  - New z_re and z_im are truncated to DATA_W; wrap is acceptable because escape was already checked.
  - The escape compare is strict (>). |z|^2 == 4 exactly is not an escape.
- Latency:
  - Escape at depth k: k+1 ITER cycles.
  - Non-escape: max_iterations+1 ITER cycles.
  - out_valid rises on the cycle after the last ITER cycle.
- DONE:
  - out_valid=1; in_ready=0.
  - depth and max_iter_out are held stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE. in_ready=1 on the next cycle (no same-cycle accept/release overlap).
- max_iterations=0: the first ITER cycle hits rule 1, giving depth=0 and max_iter_out=0.
- Outside IDLE, in_ready=0 and input changes are ignored.

Optional Feature:
- Macro: MANDEL_BULB_CHECK_EN.
- Defined:
  - A CHECK state follows the accept and lasts 1 cycle.
  - If (c_re+1)^2 + c_im^2 < 1/16 (period-2 bulb), set depth=max_iter and go straight to DONE.
  - Otherwise go to ITER.
  - Adds 1 cycle of latency to every point.
- Undefined: the CHECK state does not exist; the accept goes directly to ITER.

Test Plan:
- c=1.0+0i (0x1000_0000,0), max=100: z passes 1, 2 (|z|^2=4, not >4), 5 -> depth=3, max_iter_out=100, out_valid 5 cycles after the accept (4 ITER cycles).
- c=-2.0+0i (0xE000_0000,0), max=50: z holds at 2 with |z|^2==4 each iteration -> depth=50 (strict-compare boundary).
- c=0+0i, max=0: depth=0 after 1 ITER cycle; c=0, max=1023: depth=1023.
- Backpressure: c=2.0+0i, max=10 gives depth=2. Hold out_ready=0 for 20 cycles -> depth stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> handshake completes, in_ready=1 on the next cycle.
- Reset: assert rst_n=0 mid-ITER on c=0, max=500 -> out_valid=0 and in_ready=1 immediately. The next point c=1.0 yields depth=3.
- MANDEL_BULB_CHECK_EN, c=-1.0+0i, max=1000: with the macro, depth=1000 after 1 CHECK cycle. Without it, depth=1000 after 1001 ITER cycles.
